// File: rtl/key_inverse_expansion.sv
// key_inverse_expansion: walks the AES-128 key schedule backwards from the round-10 key,
// streaming round keys NUM_ROUNDS..0 over a valid/ready handshake.
module key_inverse_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic         abort,
    input  logic         key_ready,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d, inv_key;
    logic [3:0]   round_q, round_d, rc_idx;
    logic [31:0]  w3, rot, sub, rc;

    // Previous key's w3 is recoverable directly; w0 then needs the forward g() of that w3.
    always_comb begin
        w3     = key_q[31:0] ^ key_q[63:32];
        rot    = {w3[23:0], w3[31:24]};
        rc_idx = round_q - 4'd1;
        rc     = {(rc_idx < 4'd10) ? RCON[rc_idx] : 8'h00, 24'h0};
        sub    = '0;
        for (int b = 0; b < 4; b++)
            sub[8*b +: 8] = SBOX[rot[8*b +: 8]];
        inv_key = {key_q[127:96] ^ sub ^ rc,
                   key_q[95:64] ^ key_q[127:96],
                   key_q[63:32] ^ key_q[95:64],
                   w3};
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        if (abort)
            state_d = IDLE;
        else
            unique case (state_q)
                IDLE: if (start) begin
                    key_d   = last_key;
                    round_d = 4'(NUM_ROUNDS);
                    state_d = EMIT;
                end
                EMIT: if (key_ready) begin
                    key_d   = (round_q != 4'd0) ? inv_key : key_q;
                    round_d = (round_q != 4'd0) ? round_q - 4'd1 : round_q;
                    state_d = (round_q != 4'd0) ? EMIT : FIN;
                end
                default: state_d = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign key_out   = key_q;
    assign key_round = round_q;
    assign key_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
endmodule

// File: tb/tb_key_inverse_expansion.sv
// tb_key_inverse_expansion: directed checks of the inverse AES-128 key walk
// against FIPS-197 A.1 round keys and the all-zero-key schedule.
module tb_key_inverse_expansion;
    logic         clk = 0, rst_n = 0, start = 0, abort = 0, key_ready = 0;
    logic [127:0] last_key = '0, key_out;
    logic [3:0]   key_round;
    logic         key_valid, busy, done;
    int           passed = 0, total = 0;

    logic [127:0] K [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;

    key_inverse_expansion #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_key(last_key), .abort(abort),
        .key_ready(key_ready), .key_out(key_out), .key_round(key_round),
        .key_valid(key_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_key"}, key_out, '0);
        chk({tag, "_round"}, 128'(key_round), '0);
        chk({tag, "_valid"}, 128'(key_valid), '0);
        chk({tag, "_busy"}, 128'(busy), '0);
        chk({tag, "_done"}, 128'(done), '0);
    endtask

    // Consume the FIPS stream from round 'first'; optional random backpressure and start pokes at round 5.
    task automatic walk(input int first, input bit rnd);
        int er = first, hs = 0;
        for (int c = 0; c < 300 && key_valid; c++) begin
            chk($sformatf("walk_round%0d", er), 128'(key_round), 128'(er));
            if (er >= 0 && er <= 10) chk($sformatf("walk_key%0d", er), key_out, K[er]);
            key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = (er == 5);
            last_key  = (er == 5) ? Z10 : K[10];
            step();
            if (key_ready) begin er--; hs++; end
        end
        start = 0;
        last_key = K[10];
        chk("walk_ended", 128'(key_valid), 0);
        chk("walk_handshakes", 128'(hs), 128'(first + 1));
        chk("walk_done", 128'(done), 1);
        chk("walk_busy_at_done", 128'(busy), 1);
        key_ready = 1;
        step();
        chk("walk_done_drop", 128'(done), 0);
        chk("walk_busy_drop", 128'(busy), 0);
    endtask

    initial begin
        #12;
        outs_zero("reset");
        rst_n = 1;
        step();

        // Full FIPS-197 A.1 walk with key_ready held high.
        last_key = K[10]; start = 1; key_ready = 1;
        step();
        start = 0;
        chk("t1_valid", 128'(key_valid), 1);
        chk("t1_busy", 128'(busy), 1);
        chk("t1_round10", 128'(key_round), 10);
        chk("t1_key10", key_out, K[10]);
        for (int r = 9; r >= 0; r--) begin
            step();
            chk($sformatf("t1_round%0d", r), 128'(key_round), 128'(r));
            chk($sformatf("t1_key%0d", r), key_out, K[r]);
            chk($sformatf("t1_valid%0d", r), 128'(key_valid), 1);
        end
        step();
        chk("t1_done", 128'(done), 1);
        chk("t1_valid_off", 128'(key_valid), 0);
        chk("t1_busy_with_done", 128'(busy), 1);
        step();
        chk("t1_done_off", 128'(done), 0);
        chk("t1_busy_off", 128'(busy), 0);
        chk("t1_key_hold", key_out, K[0]);
        chk("t1_round_hold", 128'(key_round), 0);

        // Backpressure for 5 cycles at round 9.
        start = 1;
        step();
        start = 0;
        step();
        chk("bp_round9", 128'(key_round), 9);
        key_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp_hold_round%0d", i), 128'(key_round), 9);
            chk($sformatf("bp_hold_key%0d", i), key_out, K[9]);
        end
        key_ready = 1;
        step();
        chk("bp_resume_round8", 128'(key_round), 8);
        chk("bp_resume_key8", key_out, K[8]);
        walk(8, 0);

        // Random backpressure with start poked while busy at round 5.
        start = 1;
        step();
        start = 0;
        walk(10, 1);

        // Abort at round 6 alongside key_ready and start.
        start = 1;
        step();
        start = 0;
        repeat (4) step();
        chk("ab_round6", 128'(key_round), 6);
        abort = 1; start = 1; key_ready = 1;
        step();
        abort = 0; start = 0;
        chk("ab_valid", 128'(key_valid), 0);
        chk("ab_busy", 128'(busy), 0);
        chk("ab_done", 128'(done), 0);
        step();
        chk("ab_no_done", 128'(done), 0);
        chk("ab_idle", 128'(busy), 0);
        last_key = Z10; start = 1;
        step();
        start = 0;
        chk("z_key10", key_out, Z10);
        chk("z_round10", 128'(key_round), 10);
        repeat (9) step();
        chk("z_key1", key_out, Z1);
        chk("z_round1", 128'(key_round), 1);
        step();
        chk("z_key0", key_out, '0);
        chk("z_round0", 128'(key_round), 0);
        step();
        chk("z_done", 128'(done), 1);
        step();
        last_key = K[10];

        // Asynchronous reset mid-walk at round 3.
        start = 1;
        step();
        start = 0;
        repeat (7) step();
        chk("rst_round3", 128'(key_round), 3);
        #2 rst_n = 0;
        #1 outs_zero("async_rst");
        #3 rst_n = 1;
        step();
        step();
        outs_zero("post_rst_idle");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
